// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester and memory-side signals of the IF/MEM memory port arbiter.
// The mem_err line exists only when MEM_ARB_TIMEOUT_EN is defined.
interface mem_port_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_done;
    logic        if_stall;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;
    logic        dm_done;
    logic        dm_stall;
    logic        addr_sel;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
`ifdef MEM_ARB_TIMEOUT_EN
    logic        mem_err;
`endif

    // Arbiter side
    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
        output if_rdata, if_done, if_stall, dm_rdata, dm_done, dm_stall,
        output addr_sel, mem_req, mem_we, mem_addr, mem_wdata
`ifdef MEM_ARB_TIMEOUT_EN
        , output mem_err
`endif
    );

    // Pipeline stages plus memory model side
    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ack,
        input  if_rdata, if_done, if_stall, dm_rdata, dm_done, dm_stall,
        input  addr_sel, mem_req, mem_we, mem_addr, mem_wdata
`ifdef MEM_ARB_TIMEOUT_EN
        , input mem_err
`endif
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between the IF and MEM pipeline stages,
// one transaction at a time. Define MEM_ARB_TIMEOUT_EN to add a no-ack timeout abort (mem_err).
module mem_port_arbiter
`ifdef MEM_ARB_TIMEOUT_EN
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_W           = 8
)
`endif
(
    input  logic              clk,
    input  logic              rst_n,
    mem_port_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GNT_IF = 2'd1,
        GNT_DM = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t      state_r, state_s;
    logic        last_dm_r, last_dm_s;
    logic        mem_req_r, mem_req_s;
    logic        mem_we_r, mem_we_s;
    logic        addr_sel_r, addr_sel_s;
    logic [31:0] mem_addr_r, mem_addr_s;
    logic [31:0] mem_wdata_r, mem_wdata_s;
    logic [31:0] if_rdata_r, if_rdata_s;
    logic [31:0] dm_rdata_r, dm_rdata_s;
    logic        if_done_r, if_done_s;
    logic        dm_done_r, dm_done_s;
`ifdef MEM_ARB_TIMEOUT_EN
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    logic [TO_W-1:0] to_cnt_r, to_cnt_s;
    logic            mem_err_r, mem_err_s;
`endif

    // Next-state, grant latching and completion logic
    always_comb begin
        state_s     = state_r;
        last_dm_s   = last_dm_r;
        mem_req_s   = mem_req_r;
        mem_we_s    = mem_we_r;
        addr_sel_s  = addr_sel_r;
        mem_addr_s  = mem_addr_r;
        mem_wdata_s = mem_wdata_r;
        if_rdata_s  = if_rdata_r;
        dm_rdata_s  = dm_rdata_r;
        if_done_s   = 1'b0;
        dm_done_s   = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
        to_cnt_s    = to_cnt_r;
        mem_err_s   = 1'b0;
`endif
        case (state_r)
            IDLE: begin
                // On a tie the requester that did not win last time is served
                if (bus.dm_req && (!bus.if_req || !last_dm_r)) begin
                    state_s     = GNT_DM;
                    last_dm_s   = 1'b1;
                    mem_req_s   = 1'b1;
                    addr_sel_s  = 1'b1;
                    mem_addr_s  = bus.dm_addr;
                    mem_we_s    = bus.dm_we;
                    mem_wdata_s = bus.dm_wdata;
`ifdef MEM_ARB_TIMEOUT_EN
                    to_cnt_s    = {TO_W{1'b0}};
`endif
                end else if (bus.if_req) begin
                    state_s     = GNT_IF;
                    last_dm_s   = 1'b0;
                    mem_req_s   = 1'b1;
                    addr_sel_s  = 1'b0;
                    mem_addr_s  = bus.if_addr;
                    mem_we_s    = 1'b0;
                    mem_wdata_s = 32'h0000_0000;
`ifdef MEM_ARB_TIMEOUT_EN
                    to_cnt_s    = {TO_W{1'b0}};
`endif
                end else begin
                    state_s = IDLE;
                end
            end
            GNT_IF, GNT_DM: begin
                if (bus.mem_ack) begin
                    state_s   = RESP;
                    mem_req_s = 1'b0;
                    mem_we_s  = 1'b0;
                    if (state_r == GNT_IF) begin
                        if_rdata_s = bus.mem_rdata;
                        if_done_s  = 1'b1;
                    end else begin
                        if (!mem_we_r) begin
                            dm_rdata_s = bus.mem_rdata;
                        end else begin
                            dm_rdata_s = dm_rdata_r;
                        end
                        dm_done_s = 1'b1;
                    end
                end
`ifdef MEM_ARB_TIMEOUT_EN
                else if (to_cnt_r == TO_LAST) begin
                    state_s   = RESP;
                    mem_req_s = 1'b0;
                    mem_we_s  = 1'b0;
                    mem_err_s = 1'b1;
                    if (state_r == GNT_IF) begin
                        if_rdata_s = 32'hDEAD_BEEF;
                        if_done_s  = 1'b1;
                    end else begin
                        dm_rdata_s = 32'hDEAD_BEEF;
                        dm_done_s  = 1'b1;
                    end
                end else begin
                    to_cnt_s = to_cnt_r + TO_W'(1);
                end
`else
                else begin
                    state_s = state_r;
                end
`endif
            end
            RESP: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and registered-output update; reset discards any transaction in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            last_dm_r   <= 1'b0;
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            addr_sel_r  <= 1'b0;
            mem_addr_r  <= 32'h0000_0000;
            mem_wdata_r <= 32'h0000_0000;
            if_rdata_r  <= 32'h0000_0000;
            dm_rdata_r  <= 32'h0000_0000;
            if_done_r   <= 1'b0;
            dm_done_r   <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
            to_cnt_r    <= {TO_W{1'b0}};
            mem_err_r   <= 1'b0;
`endif
        end else begin
            state_r     <= state_s;
            last_dm_r   <= last_dm_s;
            mem_req_r   <= mem_req_s;
            mem_we_r    <= mem_we_s;
            addr_sel_r  <= addr_sel_s;
            mem_addr_r  <= mem_addr_s;
            mem_wdata_r <= mem_wdata_s;
            if_rdata_r  <= if_rdata_s;
            dm_rdata_r  <= dm_rdata_s;
            if_done_r   <= if_done_s;
            dm_done_r   <= dm_done_s;
`ifdef MEM_ARB_TIMEOUT_EN
            to_cnt_r    <= to_cnt_s;
            mem_err_r   <= mem_err_s;
`endif
        end
    end

    // Stalls are combinational but forced low while reset is asserted
    assign bus.if_stall  = rst_n & bus.if_req & ~if_done_r;
    assign bus.dm_stall  = rst_n & bus.dm_req & ~dm_done_r;
    assign bus.if_done   = if_done_r;
    assign bus.dm_done   = dm_done_r;
    assign bus.if_rdata  = if_rdata_r;
    assign bus.dm_rdata  = dm_rdata_r;
    assign bus.addr_sel  = addr_sel_r;
    assign bus.mem_req   = mem_req_r;
    assign bus.mem_we    = mem_we_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;
`ifdef MEM_ARB_TIMEOUT_EN
    assign bus.mem_err   = mem_err_r;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus a randomized run checked against a
// transaction-level model of grant order, occupancy timing and read-data capture.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    int          n_checks = 0;
    int          n_fail = 0;
    bit          rsp_en = 1'b0;
    bit          rsp_rand = 1'b0;
    bit          rsp_fixed = 1'b0;
    int          rsp_lat = 1;
    int          rsp_cnt = 0;
    logic [31:0] rsp_word = 32'h0;
    logic [31:0] exp_if_rd = 32'h0;
    logic [31:0] exp_dm_rd = 32'h0;

    always #5 clk = ~clk;

    mem_port_arbiter_if bus();
`ifdef MEM_ARB_TIMEOUT_EN
    mem_port_arbiter #(.TIMEOUT_CYCLES(5), .TO_W(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`else
    mem_port_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

    // Memory model: acks rsp_lat cycles after mem_req rises, garbage on the bus otherwise
    initial begin
        forever begin
            @(negedge clk);
            if (rsp_en) begin
                if (bus.mem_req && !bus.mem_ack && (rsp_cnt + 1 >= rsp_lat)) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = rsp_fixed ? 32'h2402_000A : $urandom;
                    rsp_word      = bus.mem_rdata;
                    rsp_cnt       = 0;
                    if (rsp_rand) rsp_lat = $urandom_range(1, 4);
                end else begin
                    if (bus.mem_req && !bus.mem_ack) rsp_cnt++; else rsp_cnt = 0;
                    bus.mem_ack   = 1'b0;
                    bus.mem_rdata = $urandom;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        bus.if_req = 1'b0; bus.dm_req = 1'b0; bus.dm_we = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_if_rd = 32'h0;
        exp_dm_rd = 32'h0;
    endtask

    task automatic test_reset();
        bus.if_req = 1'b1; bus.dm_req = 1'b1;
        repeat (2) step();
        n_checks++;
        if ({bus.if_rdata, bus.if_done, bus.if_stall, bus.dm_rdata, bus.dm_done, bus.dm_stall, bus.addr_sel,
             bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== 135'h0) begin
            n_fail++; $display("FAIL reset_outputs: got nonzero, mem_req=%b if_stall=%b dm_stall=%b expected all 0",
                               bus.mem_req, bus.if_stall, bus.dm_stall);
        end
        @(negedge clk);
        bus.if_req = 1'b0; bus.dm_req = 1'b0; rst_n = 1'b1;
        step();
        n_checks++;
        if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_idle_mem_req: got %b expected 0", bus.mem_req); end
    endtask

    task automatic test_if_read();
        int req_cycles;
        bit seen;
        req_cycles = 0; seen = 1'b0;
        rsp_en = 1'b1; rsp_rand = 1'b0; rsp_lat = 2; rsp_fixed = 1'b1;
        @(negedge clk);
        bus.if_req = 1'b1; bus.if_addr = 32'h40;
        for (int c = 0; c < 20 && !seen; c++) begin
            step();
            n_checks++;
            if (bus.dm_stall !== 1'b0) begin n_fail++; $display("FAIL if_read_dm_stall: got %b expected 0", bus.dm_stall); end
            if (bus.mem_req === 1'b1) begin
                req_cycles++;
                n_checks++;
                if ({bus.addr_sel, bus.mem_addr} !== {1'b0, 32'h40}) begin
                    n_fail++; $display("FAIL if_read_grant: got sel=%b addr=%h expected sel=0 addr=00000040", bus.addr_sel, bus.mem_addr);
                end
            end
            n_checks++;
            if (bus.if_done === 1'b1) begin
                seen = 1'b1;
                if ({bus.if_rdata, bus.if_stall} !== {32'h2402_000A, 1'b0}) begin
                    n_fail++; $display("FAIL if_read_data: got rdata=%h stall=%b expected 2402000a stall=0", bus.if_rdata, bus.if_stall);
                end
            end else if (bus.if_stall !== 1'b1) begin
                n_fail++; $display("FAIL if_read_stall: got %b expected 1", bus.if_stall);
            end
        end
        n_checks++;
        if (!seen || req_cycles != 2) begin n_fail++; $display("FAIL if_read_latency: done=%b mem_req cycles=%0d expected 2", seen, req_cycles); end
        exp_if_rd = 32'h2402_000A;
        @(negedge clk);
        bus.if_req = 1'b0; rsp_fixed = 1'b0;
        step();
        n_checks++;
        if (bus.if_done !== 1'b0) begin n_fail++; $display("FAIL if_read_single_pulse: got %b expected 0", bus.if_done); end
    endtask

    task automatic test_simultaneous();
        bit first_done, dm_seen, if_seen;
        first_done = 1'b0; dm_seen = 1'b0; if_seen = 1'b0;
        do_reset();
        rsp_lat = 1; rsp_rand = 1'b0;
        @(negedge clk);
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h200;
        bus.if_req = 1'b1; bus.if_addr = 32'h44;
        for (int c = 0; c < 30 && !if_seen; c++) begin
            step();
            if (bus.mem_req === 1'b1 && !first_done) begin
                first_done = 1'b1;
                n_checks++;
                if ({bus.addr_sel, bus.mem_addr} !== {1'b1, 32'h200}) begin
                    n_fail++; $display("FAIL simul_first_dm: got sel=%b addr=%h expected sel=1 addr=00000200", bus.addr_sel, bus.mem_addr);
                end
            end
            if (!dm_seen) begin
                n_checks++;
                if (bus.if_stall !== 1'b1) begin n_fail++; $display("FAIL simul_if_stall: got %b expected 1", bus.if_stall); end
                if (bus.dm_done === 1'b1) begin
                    dm_seen = 1'b1; exp_dm_rd = rsp_word; bus.dm_req = 1'b0;
                end
            end else if (bus.mem_req === 1'b1) begin
                n_checks++;
                if ({bus.addr_sel, bus.mem_addr} !== {1'b0, 32'h44}) begin
                    n_fail++; $display("FAIL simul_second_if: got sel=%b addr=%h expected sel=0 addr=00000044", bus.addr_sel, bus.mem_addr);
                end
            end
            if (bus.if_done === 1'b1) begin
                if_seen = 1'b1;
                n_checks++;
                if (bus.if_rdata !== rsp_word) begin n_fail++; $display("FAIL simul_if_rdata: got %h expected %h", bus.if_rdata, rsp_word); end
                exp_if_rd = rsp_word; bus.if_req = 1'b0;
            end
        end
        n_checks++;
        if ({dm_seen, if_seen} !== 2'b11) begin n_fail++; $display("FAIL simul_completion: got dm=%b if=%b expected 1 1", dm_seen, if_seen); end
        bus.dm_req = 1'b0; bus.if_req = 1'b0;
    endtask

    task automatic test_back_to_back();
        int n_done, last_c;
        n_done = 0; last_c = -1;
        do_reset();
        rsp_lat = 1; rsp_rand = 1'b0;
        @(negedge clk);
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h300;
        bus.if_req = 1'b1; bus.if_addr = 32'h48;
        for (int c = 0; c < 40 && n_done < 4; c++) begin
            step();
            if (bus.if_done === 1'b1 || bus.dm_done === 1'b1) begin
                n_checks++;
                if ({bus.dm_done, bus.if_done} !== ((n_done % 2 == 0) ? 2'b10 : 2'b01)) begin
                    n_fail++; $display("FAIL b2b_order_%0d: got dm=%b if=%b", n_done, bus.dm_done, bus.if_done);
                end
                if (n_done > 0) begin
                    n_checks++;
                    if (c - last_c != 3) begin n_fail++; $display("FAIL b2b_spacing_%0d: got %0d cycles expected 3", n_done, c - last_c); end
                end
                if (bus.dm_done === 1'b1) exp_dm_rd = rsp_word; else exp_if_rd = rsp_word;
                n_checks++;
                if ({bus.if_rdata, bus.dm_rdata} !== {exp_if_rd, exp_dm_rd}) begin
                    n_fail++; $display("FAIL b2b_rdata_%0d: got if=%h dm=%h expected if=%h dm=%h", n_done, bus.if_rdata, bus.dm_rdata, exp_if_rd, exp_dm_rd);
                end
                last_c = c; n_done++;
            end
        end
        n_checks++;
        if (n_done != 4) begin n_fail++; $display("FAIL b2b_count: got %0d done pulses expected 4", n_done); end
        bus.dm_req = 1'b0; bus.if_req = 1'b0;
        repeat (3) step();
    endtask

    task automatic test_dm_write();
        int dones, gnt;
        dones = 0; gnt = 0;
        rsp_lat = 2; rsp_rand = 1'b0;
        @(negedge clk);
        bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 32'h100; bus.dm_wdata = 32'd30;
        for (int c = 0; c < 15; c++) begin
            step();
            if (bus.mem_req === 1'b1) begin
                gnt++;
                n_checks++;
                if ({bus.mem_we, bus.mem_wdata, bus.addr_sel, bus.mem_addr} !== {1'b1, 32'd30, 1'b1, 32'h100}) begin
                    n_fail++; $display("FAIL dm_write_grant: got we=%b wdata=%0d sel=%b addr=%h expected we=1 wdata=30 sel=1 addr=00000100",
                                       bus.mem_we, bus.mem_wdata, bus.addr_sel, bus.mem_addr);
                end
            end
            if (bus.dm_done === 1'b1) begin
                dones++;
                n_checks++;
                if ({bus.dm_rdata, bus.mem_we} !== {exp_dm_rd, 1'b0}) begin
                    n_fail++; $display("FAIL dm_write_rdata_kept: got %h we=%b expected %h we=0", bus.dm_rdata, bus.mem_we, exp_dm_rd);
                end
                bus.dm_req = 1'b0; bus.dm_we = 1'b0;
            end
        end
        n_checks++;
        if (dones != 1 || gnt != 2) begin n_fail++; $display("FAIL dm_write_pulses: got done=%0d grant cycles=%0d expected 1 and 2", dones, gnt); end
    endtask

    task automatic test_reset_mid();
        bit gnt;
        gnt = 1'b0;
        rsp_en = 1'b0; bus.mem_ack = 1'b0;
        @(negedge clk);
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h180;
        for (int c = 0; c < 5 && !gnt; c++) begin
            step();
            if (bus.mem_req === 1'b1) gnt = 1'b1;
        end
        n_checks++;
        if (!gnt) begin n_fail++; $display("FAIL reset_mid_grant: got no grant expected one"); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.if_rdata, bus.if_done, bus.if_stall, bus.dm_rdata, bus.dm_done, bus.dm_stall, bus.addr_sel,
             bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== 135'h0) begin
            n_fail++; $display("FAIL reset_mid_outputs: got mem_req=%b addr_sel=%b dm_stall=%b dm_rdata=%h expected all 0",
                               bus.mem_req, bus.addr_sel, bus.dm_stall, bus.dm_rdata);
        end
        @(negedge clk);
        rst_n = 1'b1; bus.dm_req = 1'b0; bus.mem_ack = 1'b1; bus.mem_rdata = 32'h1234_5678;
        step();
        n_checks++;
        if ({bus.dm_done, bus.mem_req, bus.dm_rdata} !== 34'h0) begin
            n_fail++; $display("FAIL reset_mid_late_ack: got done=%b req=%b rdata=%h expected 0", bus.dm_done, bus.mem_req, bus.dm_rdata);
        end
        @(negedge clk);
        bus.mem_ack = 1'b0;
        step();
        n_checks++;
        if (bus.dm_done !== 1'b0) begin n_fail++; $display("FAIL reset_mid_no_done: got %b expected 0", bus.dm_done); end
        exp_dm_rd = 32'h0; exp_if_rd = 32'h0;
        rsp_en = 1'b1;
    endtask

`ifdef MEM_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int hi;
        bit seen;
        hi = 0; seen = 1'b0;
        do_reset();
        rsp_en = 1'b0; bus.mem_ack = 1'b0;
        @(negedge clk);
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_addr = 32'h1C0;
        for (int c = 0; c < 30 && !seen; c++) begin
            step();
            if (bus.mem_req === 1'b1) hi++;
            n_checks++;
            if (bus.dm_done === 1'b1) begin
                seen = 1'b1; bus.dm_req = 1'b0;
                if ({bus.mem_err, bus.dm_rdata} !== {1'b1, 32'hDEAD_BEEF}) begin
                    n_fail++; $display("FAIL timeout_abort: got err=%b rdata=%h expected 1 deadbeef", bus.mem_err, bus.dm_rdata);
                end
            end else if (bus.mem_err !== 1'b0) begin
                n_fail++; $display("FAIL timeout_early_err: got %b expected 0", bus.mem_err);
            end
        end
        n_checks++;
        if (!seen || hi != 5) begin n_fail++; $display("FAIL timeout_length: done=%b mem_req cycles=%0d expected 5", seen, hi); end
        step();
        n_checks++;
        if ({bus.mem_err, bus.dm_done} !== 2'b00) begin n_fail++; $display("FAIL timeout_pulse: got err=%b done=%b expected 0 0", bus.mem_err, bus.dm_done); end
        exp_dm_rd = 32'hDEAD_BEEF;
        rsp_en = 1'b1;
    endtask
`endif

    // Transaction-level model: grants happen only when the port is free (two edges after
    // the previous ack), ties alternate, done follows the ack edge, data is the acked word.
    task automatic test_random();
        bit owner_valid, owner_dm, last_dm, if_fin, dm_fin, exp_if_done, exp_dm_done, l_we;
        int free_e;
        logic [31:0] l_addr, l_wd;
        owner_valid = 1'b0; owner_dm = 1'b0; last_dm = 1'b0; if_fin = 1'b0; dm_fin = 1'b0;
        l_we = 1'b0; l_addr = 32'h0; l_wd = 32'h0; free_e = 0;
        do_reset();
        rsp_en = 1'b1; rsp_rand = 1'b1; rsp_lat = $urandom_range(1, 4);
        for (int e = 0; e < 600; e++) begin
            @(negedge clk);
            if (if_fin) bus.if_req = 1'b0;
            else if (!bus.if_req && $urandom_range(0, 2) == 0) begin
                bus.if_req = 1'b1; bus.if_addr = $urandom;
            end
            if (dm_fin) bus.dm_req = 1'b0;
            else if (!bus.dm_req && $urandom_range(0, 2) == 0) begin
                bus.dm_req = 1'b1; bus.dm_addr = $urandom; bus.dm_wdata = $urandom; bus.dm_we = 1'($urandom_range(0, 1));
            end
            step();
            exp_if_done = 1'b0; exp_dm_done = 1'b0;
            if (owner_valid) begin
                if (bus.mem_ack === 1'b1) begin
                    owner_valid = 1'b0; free_e = e + 2;
                    if (owner_dm) begin exp_dm_done = 1'b1; if (!l_we) exp_dm_rd = rsp_word; end
                    else begin exp_if_done = 1'b1; exp_if_rd = rsp_word; end
                end
            end else if (e >= free_e && (bus.if_req || bus.dm_req)) begin
                owner_valid = 1'b1;
                owner_dm = (bus.if_req && bus.dm_req) ? !last_dm : bus.dm_req;
                last_dm = owner_dm;
                l_addr = owner_dm ? bus.dm_addr : bus.if_addr;
                l_we   = owner_dm ? bus.dm_we : 1'b0;
                l_wd   = owner_dm ? bus.dm_wdata : 32'h0;
            end
            n_checks++;
            if ({bus.mem_req, bus.mem_we} !== {owner_valid, owner_valid & l_we}) begin
                n_fail++; $display("FAIL rnd_mem_req@%0d: got req=%b we=%b expected req=%b we=%b", e, bus.mem_req, bus.mem_we, owner_valid, owner_valid & l_we);
            end
            if (owner_valid) begin
                n_checks++;
                if ({bus.addr_sel, bus.mem_addr, bus.mem_wdata} !== {owner_dm, l_addr, l_wd}) begin
                    n_fail++; $display("FAIL rnd_grant@%0d: got sel=%b addr=%h wd=%h expected sel=%b addr=%h wd=%h",
                                       e, bus.addr_sel, bus.mem_addr, bus.mem_wdata, owner_dm, l_addr, l_wd);
                end
            end
            n_checks++;
            if ({bus.if_done, bus.dm_done} !== {exp_if_done, exp_dm_done}) begin
                n_fail++; $display("FAIL rnd_done@%0d: got if=%b dm=%b expected if=%b dm=%b", e, bus.if_done, bus.dm_done, exp_if_done, exp_dm_done);
            end
            n_checks++;
            if ({bus.if_rdata, bus.dm_rdata} !== {exp_if_rd, exp_dm_rd}) begin
                n_fail++; $display("FAIL rnd_rdata@%0d: got if=%h dm=%h expected if=%h dm=%h", e, bus.if_rdata, bus.dm_rdata, exp_if_rd, exp_dm_rd);
            end
            n_checks++;
            if ({bus.if_stall, bus.dm_stall} !== {bus.if_req & ~exp_if_done, bus.dm_req & ~exp_dm_done}) begin
                n_fail++; $display("FAIL rnd_stall@%0d: got if=%b dm=%b", e, bus.if_stall, bus.dm_stall);
            end
            if_fin = exp_if_done; dm_fin = exp_dm_done;
        end
        bus.if_req = 1'b0; bus.dm_req = 1'b0;
    endtask

    initial begin
        bus.if_req = 1'b0; bus.if_addr = 32'h0;
        bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = 32'h0; bus.dm_wdata = 32'h0;
        bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;
        test_reset();
        test_if_read();
        test_simultaneous();
        test_back_to_back();
        test_dm_write();
        test_reset_mid();
`ifdef MEM_ARB_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
